// File: rtl/v74x139_3_decoder_pkg.sv
// Shared constants and the select-to-one-cold mapping for the registered 2-to-4 decoder.
package v74x139_pkg;

    localparam int SEL_W = 2;
    localparam int OUT_W = 4;
    localparam logic [OUT_W-1:0] Y_IDLE = 4'b1111;

    function automatic logic [OUT_W-1:0] sel_to_one_cold(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] pattern;
        pattern = Y_IDLE;
        case (sel)
            2'd0:    pattern = 4'b1110;
            2'd1:    pattern = 4'b1101;
            2'd2:    pattern = 4'b1011;
            2'd3:    pattern = 4'b0111;
            default: pattern = Y_IDLE;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/v74x139_3_decoder_if.sv
// Enable, select and decoded-output bundle of one 74x139 decoder section.
interface v74x139_3_decoder_if;
    import v74x139_pkg::*;

    logic             g_l;
    logic             a;
    logic             b;
    logic [OUT_W-1:0] y_l;

    modport master (
        output g_l,
        output a,
        output b,
        input  y_l
    );

    modport slave (
        input  g_l,
        input  a,
        input  b,
        output y_l
    );

endinterface

// File: rtl/v74x139_3_decoder_dec2to4.sv
// Combinational 2-to-4 decode with active-low enable; feeds the output register.
module v74x139_dec2to4
    import v74x139_pkg::*;
(
    input  logic             g_l,
    input  logic             a,
    input  logic             b,
    output logic [OUT_W-1:0] y_l_next
);

    always_comb begin
        y_l_next = Y_IDLE;
        if (!g_l) begin
            y_l_next = sel_to_one_cold({b, a});
        end
    end

endmodule

// File: rtl/v74x139_3_decoder.sv
// Registered 2-to-4 decoder, active-low enable and outputs (one 74x139 section).
// Define V74X139_ONEHOT_CHECK_EN to compile in simulation-only output legality checks.
module v74x139_3_decoder
    import v74x139_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    v74x139_3_decoder_if.slave  dec
);

    logic [OUT_W-1:0] y_l_p0;
    logic [OUT_W-1:0] y_l_p1;

    v74x139_dec2to4 u_dec (
        .g_l      (dec.g_l),
        .a        (dec.a),
        .b        (dec.b),
        .y_l_next (y_l_p0)
    );

    // Stage p0 -> p1: outputs change only on the clock edge, so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_l_p1 <= Y_IDLE;
        end else begin
            y_l_p1 <= y_l_p0;
        end
    end

    assign dec.y_l = y_l_p1;

`ifdef V74X139_ONEHOT_CHECK_EN
    logic g_l_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_l_p1 <= 1'b1;
        end else begin
            g_l_p1 <= dec.g_l;
        end
    end

    // Sampled before this edge's update, so y_l_p1 and g_l_p1 belong to the same decode.
    always @(posedge clk) begin
        if (!rst) begin
            if ($countones(~y_l_p1) > 1)
                $error("t=%0t y_l=%b has more than one active output", $time, y_l_p1);
            if (!g_l_p1 && $countones(~y_l_p1) != 1)
                $error("t=%0t y_l=%b enabled but not exactly one active output", $time, y_l_p1);
            if (g_l_p1 && y_l_p1 != Y_IDLE)
                $error("t=%0t y_l=%b disabled but not idle", $time, y_l_p1);
        end
    end
`else
`endif

endmodule

// File: tb/tb_v74x139_3_decoder.sv
// Directed-vector bench for the registered 2-to-4 decoder.
module tb_v74x139_3_decoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    v74x139_3_decoder_if dec_if ();

    v74x139_3_decoder dut (
        .clk (clk),
        .rst (rst),
        .dec (dec_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards sit mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic g, input logic [1:0] ba);
        dec_if.g_l = g;
        {dec_if.b, dec_if.a} = ba;
    endtask

    logic [3:0] en_exp [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        en_exp[0] = 4'b1110;
        en_exp[1] = 4'b1101;
        en_exp[2] = 4'b1011;
        en_exp[3] = 4'b0111;

        rst = 1'b0;
        drive(1'b0, 2'b10);
        #1 rst = 1'b1;
        #1 check("reset_async", dec_if.y_l, 4'b1111);
        step();
        check("reset_hold", dec_if.y_l, 4'b1111);
        rst = 1'b0;
        step();
        check("reset_release", dec_if.y_l, 4'b1011);

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'(i));
            check("en_before_edge", dec_if.y_l, (i == 0) ? 4'b1011 : en_exp[i-1]);
            step();
            check("en_sweep", dec_if.y_l, en_exp[i]);
            step();
            check("en_hold", dec_if.y_l, en_exp[i]);
        end

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i));
            step();
            check("dis_sweep", dec_if.y_l, 4'b1111);
            step();
            check("dis_hold", dec_if.y_l, 4'b1111);
        end

        drive(1'b0, 2'b00);
        step();
        check("lat_base", dec_if.y_l, 4'b1110);
        #2 dec_if.a = 1'b1;
        #1 check("lat_between_edges", dec_if.y_l, 4'b1110);
        step();
        check("lat_new", dec_if.y_l, 4'b1101);

        drive(1'b1, 2'b00);
        step();
        check("simul_before", dec_if.y_l, 4'b1111);
        drive(1'b0, 2'b11);
        step();
        check("simul_after", dec_if.y_l, 4'b0111);

        #2 rst = 1'b1;
        #1 check("mid_reset_async", dec_if.y_l, 4'b1111);
        step();
        check("mid_reset_hold", dec_if.y_l, 4'b1111);
        rst = 1'b0;
        #1 check("mid_reset_released", dec_if.y_l, 4'b1111);
        step();
        check("mid_reset_restore", dec_if.y_l, 4'b0111);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
